// File: rtl/uart_rx_frontend_pkg.sv
// Shared UART definitions: FSM state encoding, state_rx width and default bit period.
// The TX side reuses the same package for its state_tx debug port.
package uart_rx_frontend_pkg;

  localparam int STATE_W          = 3;
  localparam int DEF_CLKS_PER_BIT = 434;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Byte handshake between the UART receiver (master) and the bus slave reading it (slave).
interface uart_rx_frontend_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;

  modport master (output rx_data, output rx_valid, input rx_ack);
  modport slave  (input rx_data, input rx_valid, output rx_ack);

endinterface

// File: rtl/uart_rx_frontend_sync.sv
// Two-flop synchroniser for the asynchronous rx pin; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: 8N1 deserialiser with framing check, one-byte holding register
// and sticky error flags. Define UART_RX_PARITY_EN to add an even-parity bit and parity_err.
module uart_rx_frontend
  import uart_rx_frontend_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  input  logic               err_clr,
  uart_rx_frontend_if.master hs,
  output logic               frame_err,
  output logic               overrun,
`ifdef UART_RX_PARITY_EN
  output logic               parity_err,
`endif
  output logic [STATE_W-1:0] state_rx
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 done_q, done_d;
  logic                 frame_evt;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 par_evt;
  logic                 parity_err_q;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      done_q  <= done_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Sampling points are counted from the start-bit midpoint, so every later sample is mid-bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_evt   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = STOP;
          if (rx_s != ^shift_q) begin
            par_evt   = 1'b1;
            par_bad_d = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            done_d  = !par_bad_q;
`else
            done_d  = 1'b1;
`endif
          end else begin
            state_d   = WAIT_HI;
            frame_evt = 1'b1;
          end
        end
      end
      WAIT_HI: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Holding register and sticky flags; a new flag event beats a simultaneous err_clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (done_q && (!rx_valid_q || hs.rx_ack)) begin
        rx_data_q  <= shift_q;
        rx_valid_q <= 1'b1;
      end else if (hs.rx_ack) begin
        rx_valid_q <= 1'b0;
      end
      if (done_q && rx_valid_q && !hs.rx_ack) overrun_q <= 1'b1;
      else if (err_clr)                        overrun_q <= 1'b0;
      if (frame_evt)    frame_err_q <= 1'b1;
      else if (err_clr) frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (par_evt)      parity_err_q <= 1'b1;
      else if (err_clr) parity_err_q <= 1'b0;
`endif
    end
  end

  assign hs.rx_data  = rx_data_q;
  assign hs.rx_valid = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif
  assign state_rx    = state_q;

endmodule
